// File: rtl/fetch_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_unit_pkg
//  Purpose  : Shared types and constants for the instruction prefetch unit.
//  Revision : 1.0 - initial release
// ============================================================================

// Fallbacks for builds that do not provide the shared width/boot-address defines.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BOOT_ADDR
`define BOOT_ADDR 32'h0000_0000
`endif

package fetch_prefetch_unit_pkg;

  localparam int              XLEN        = `DATA_WIDTH;
  localparam logic [XLEN-1:0] RESET_PC    = `BOOT_ADDR;
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  // One instruction-queue entry: fetched word, its address, bus-error flag.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_entry_t;

  // Sequential fetch address following pc.
  function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Power-of-two circular instruction queue with flush and a
//             combinational head (no added read latency).
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        push_data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        head_data_o,
  output logic                    head_valid_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count update; pointers are exactly PW bits so they wrap modulo DEPTH.
  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o  = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_unit
//  Purpose  : Credit-based instruction prefetcher feeding a small queue, with
//             redirect flush, stale-response discard and control PC access.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] BOOT_ADDR = RESET_PC
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [XLEN-1:0]        req_addr,
  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic [XLEN-1:0]        rsp_data,
  input  logic                   rsp_err,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [XLEN-1:0]        instr_data,
  output logic [XLEN-1:0]        instr_pc,
  output logic                   instr_err,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   cm_pc_stall,
  input  logic                   cm_pc_we,
  input  logic [XLEN-1:0]        cm_pc_write_data,
  output logic [XLEN-1:0]        cm_pc_read_data,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            req_valid_q, req_valid_d;
  logic            stale_q, stale_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  // In-order record of issued addresses so each response gets its own PC.
  logic [XLEN-1:0] trk_mem_q [DEPTH];
  logic [PW-1:0]   trk_wr_q, trk_rd_q;

  logic            req_hs, drop_rsp, push_rsp, pc_write, flush, can_issue;
  logic [CW:0]     credit_used;
  fetch_entry_t    push_entry, head_entry;

  // Next-state logic: redirect beats sequential advance; a held request is never altered.
  always_comb begin
    req_hs        = req_valid_q && req_ready;
    drop_rsp      = rsp_valid && (discard_q != '0);
    push_rsp      = rsp_valid && !drop_rsp;
    pc_write      = cm_pc_we && cm_pc_stall && (outstanding_q == '0) && !req_valid_q;
    flush         = redirect_valid || pc_write;
    credit_used   = {1'b0, occupancy} + {1'b0, outstanding_q} + (CW+1)'(req_hs);
    can_issue     = !cm_pc_stall && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_valid);

    // A stale request counts as a discard the moment it is accepted.
    discard_d = discard_q - CW'(drop_rsp) + CW'(req_hs && stale_q);
    if (redirect_valid) discard_d = outstanding_d;

    stale_d = stale_q;
    if (req_hs) stale_d = 1'b0;
    if (redirect_valid && req_valid_q && !req_ready) stale_d = 1'b1;

    fetch_pc_d = fetch_pc_q;
    if (req_hs && !stale_q) fetch_pc_d = pc_advance(req_addr_q);
    if (redirect_valid)     fetch_pc_d = redirect_pc;
    else if (pc_write)      fetch_pc_d = cm_pc_write_data;

    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    if (!req_valid_q || req_ready) begin
      req_valid_d = can_issue;
      if (can_issue) req_addr_d = fetch_pc_d;
    end
  end

  // Fetch control registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fetch_pc_q    <= BOOT_ADDR;
      req_addr_q    <= BOOT_ADDR;
      req_valid_q   <= 1'b0;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      req_valid_q   <= req_valid_d;
      stale_q       <= stale_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Address tracker pointers: push on handshake, pop on every response (kept or dropped).
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      trk_wr_q <= '0;
      trk_rd_q <= '0;
    end else begin
      if (req_hs)    trk_wr_q <= trk_wr_q + PW'(1);
      if (rsp_valid) trk_rd_q <= trk_rd_q + PW'(1);
    end
  end

  // Address tracker storage.
  always_ff @(posedge CLK) begin
    if (req_hs) trk_mem_q[trk_wr_q] <= req_addr_q;
  end

  assign push_entry = '{data: rsp_data, pc: trk_mem_q[trk_rd_q], err: rsp_err};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk_i        (CLK),
    .rst_ni       (RSTn),
    .flush_i      (flush),
    .push_i       (push_rsp),
    .push_data_i  (push_entry),
    .pop_i        (instr_ready),
    .head_data_o  (head_entry),
    .head_valid_o (instr_valid),
    .count_o      (occupancy)
  );

  assign req_valid       = req_valid_q;
  assign req_addr        = req_addr_q;
  assign rsp_ready       = 1'b1;
  assign instr_data      = head_entry.data;
  assign instr_pc        = head_entry.pc;
  assign instr_err       = head_entry.err;
  assign cm_pc_read_data = fetch_pc_q;

endmodule

`default_nettype wire
